// File: rtl/charmap_pkg.sv
// Shared codes, FSM states and cursor command encoding for the character-print responder.
package charmap_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADVANCE,
    CUR_NEWLINE,
    CUR_RETURN,
    CUR_BACK
  } cur_cmd_t;

endpackage

// File: rtl/char_cursor.sv
// Text cursor: row/col registers with wrap, plus linear address of the stored and the
// "base" position (stored position, or home when the clear sequence is finishing).
module char_cursor
  import charmap_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  cur_cmd_t          cmd,
  input  logic              home,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic [ADDR_W-1:0] base_addr,
  output logic              base_col_zero
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic [COL_W-1:0] col_q, col_b, col_d;
  logic [ROW_W-1:0] row_q, row_b, row_d;

  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
    return (r == ROW_W'(ROWS - 1)) ? '0 : r + ROW_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] lin(input logic [ROW_W-1:0] r,
                                            input logic [COL_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // Homing happens before the command so a character can execute on the clear-exit edge
  assign col_b = home ? '0 : col_q;
  assign row_b = home ? '0 : row_q;

  always_comb begin
    col_d = col_b;
    row_d = row_b;
    case (cmd)
      CUR_ADVANCE: begin
        if (col_b == COL_W'(COLS - 1)) begin
          col_d = '0;
          row_d = row_inc(row_b);
        end else begin
          col_d = col_b + COL_W'(1);
        end
      end
      CUR_NEWLINE: begin
        col_d = '0;
        row_d = row_inc(row_b);
      end
      CUR_RETURN: col_d = '0;
      CUR_BACK:   if (col_b != '0) col_d = col_b - COL_W'(1);
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign cursor_addr   = lin(row_q, col_q);
  assign base_addr     = lin(row_b, col_b);
  assign base_col_zero = (col_b == '0);

endmodule

// File: rtl/char_map_writer.sv
// Character-print responder: decodes print strobes into character RAM writes, runs the
// clear-screen sweep, and buffers one character that arrives during a sweep.
module char_map_writer
  import charmap_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              charprint,
  input  logic [31:0]       writedata,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_data,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy,
  output logic              overflow
);

  localparam int CELLS = COLS * ROWS;
  localparam int SW_W  = ADDR_W + 1;

  state_t            state_q, state_d;
  logic              pend_vld_q, pend_vld_d;
  logic [7:0]        pend_code_q, pend_code_d;
  logic [SW_W-1:0]   sweep_q, sweep_d;
  logic              ovf_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        data_d;
  cur_cmd_t          cmd;
  logic              home;
  logic              exec;
  logic [7:0]        code;
  logic              sweep_last;
  logic [ADDR_W-1:0] base_addr;
  logic              base_col_zero;
  logic [7:0]        din;
  logic [23:0]       unused_hi;

  assign din        = writedata[7:0];
  assign unused_hi  = writedata[31:8];
  assign sweep_last = (state_q == CLEAR) && (sweep_q == SW_W'(CELLS));

  char_cursor #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
    .clk           (clk),
    .reset         (reset),
    .cmd           (cmd),
    .home          (home),
    .cursor_addr   (cursor_addr),
    .base_addr     (base_addr),
    .base_col_zero (base_col_zero)
  );

  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_code_d = pend_code_q;
    sweep_d     = sweep_q;
    ovf_d       = overflow;
    we_d        = 1'b0;
    addr_d      = '0;
    data_d      = SPACE;
    cmd         = CUR_NONE;
    home        = 1'b0;
    exec        = 1'b0;
    code        = din;

    if (sweep_last) begin
      state_d = IDLE;
      home    = 1'b1;
    end

    // The exit edge behaves like IDLE with the cursor already homed
    if (state_q == IDLE || sweep_last) begin
      if (pend_vld_q) begin
        exec        = 1'b1;
        code        = pend_code_q;
        pend_vld_d  = charprint;
        pend_code_d = din;
      end else begin
        exec = charprint;
      end
    end else begin
      we_d    = 1'b1;
      addr_d  = sweep_q[ADDR_W-1:0];
      sweep_d = sweep_q + SW_W'(1);
      if (charprint) begin
        if (pend_vld_q) begin
          ovf_d = 1'b1;
        end else begin
          pend_vld_d  = 1'b1;
          pend_code_d = din;
        end
      end
    end

    if (exec) begin
      case (code)
        LF: cmd = CUR_NEWLINE;
        CR: cmd = CUR_RETURN;
        BS: begin
          if (!base_col_zero) begin
            cmd    = CUR_BACK;
            we_d   = 1'b1;
            addr_d = base_addr - ADDR_W'(1);
          end
        end
        FF: begin
          state_d = CLEAR;
          sweep_d = SW_W'(1);
          we_d    = 1'b1;
        end
        default: begin
          cmd    = CUR_ADVANCE;
          we_d   = 1'b1;
          addr_d = base_addr;
          data_d = code;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pend_vld_q  <= 1'b0;
      pend_code_q <= '0;
      sweep_q     <= '0;
      overflow    <= 1'b0;
      vram_we     <= 1'b0;
      vram_addr   <= '0;
      vram_data   <= '0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_code_q <= pend_code_d;
      sweep_q     <= sweep_d;
      overflow    <= ovf_d;
      vram_we     <= we_d;
      vram_addr   <= addr_d;
      vram_data   <= data_d;
    end
  end

  assign busy = (state_q == CLEAR);

endmodule
